pc_seq_ctrl: RTL

PC_SEQ_CTRL -- requirements
Module: pc_seq_ctrl

---
 rtl/pc_seq_pkg.sv | 17 +
 rtl/pc_seq_ctrl_if.sv | 39 +++
 rtl/pc_target_gen.sv | 29 ++
 rtl/pc_seq_ctrl.sv | 115 +++++++++++
 4 files changed

// File: rtl/pc_seq_pkg.sv
// Shared types and constants for the PC sequencer.
// PC_MISALIGN_TRAP_EN adds the TRAP state.
package pc_seq_pkg;

  localparam int unsigned PC_W = 8;
  localparam logic [PC_W-1:0] RESET_PC_DEFAULT = 8'h00;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StFlush
`ifdef PC_MISALIGN_TRAP_EN
    , StTrap
`endif
  } pc_state_e;

endpackage

// File: rtl/pc_seq_ctrl_if.sv
// Decode-side control and fetch/decode address bundle for pc_seq_ctrl.
// PC_MISALIGN_TRAP_EN adds trap_ack/trap.
interface pc_seq_ctrl_if;
  import pc_seq_pkg::*;

  logic            stall;
  logic            branch;
  logic            jal;
  logic            jalr;
  logic            br_taken;
  logic [PC_W-1:0] branoff;
  logic [PC_W-1:0] pc;
  logic [PC_W-1:0] pc_d;
  logic            valid_d;
  logic            flush;
`ifdef PC_MISALIGN_TRAP_EN
  logic            trap_ack;
  logic            trap;
`endif

  modport master (
    output stall, branch, jal, jalr, br_taken, branoff,
    input  pc, pc_d, valid_d, flush
`ifdef PC_MISALIGN_TRAP_EN
    , output trap_ack
    , input  trap
`endif
  );

  modport slave (
    input  stall, branch, jal, jalr, br_taken, branoff,
    output pc, pc_d, valid_d, flush
`ifdef PC_MISALIGN_TRAP_EN
    , input  trap_ack
    , output trap
`endif
  );

endinterface

// File: rtl/pc_target_gen.sv
// Redirect target: jal/branch are pc_d-relative, jalr is absolute with bit 0 cleared.
// Without PC_MISALIGN_TRAP_EN the target is silently word-aligned.
module pc_target_gen
  import pc_seq_pkg::*;
(
  input  logic            jal_i,
  input  logic            jalr_i,
  input  logic [PC_W-1:0] pc_d_i,
  input  logic [PC_W-1:0] branoff_i,
  output logic [PC_W-1:0] target_o
);

  logic [PC_W-1:0] raw;

  always_comb begin
    // jal outranks jalr; plain branches share the relative adder with jal
    if (jalr_i && !jal_i) begin
      raw = {branoff_i[PC_W-1:1], 1'b0};
    end else begin
      raw = pc_d_i + branoff_i;
    end
`ifdef PC_MISALIGN_TRAP_EN
    target_o = raw;
`else
    target_o = raw & ~PC_W'(3);
`endif
  end

endmodule

// File: rtl/pc_seq_ctrl.sv
// Fetch PC sequencer: sequential fetch, stall hold, one-cycle flush on taken redirects.
// PC_MISALIGN_TRAP_EN enables trapping on targets with bit 1 set.
module pc_seq_ctrl
  import pc_seq_pkg::*;
#(
  parameter logic [PC_W-1:0] RESET_PC = RESET_PC_DEFAULT
) (
  input logic          clk,
  input logic          rst,
  pc_seq_ctrl_if.slave bus
);

  pc_state_e       state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic [PC_W-1:0] dec_pc_q, dec_pc_d;
  logic            dec_vld_q, dec_vld_d;
  logic            flush_q, flush_d;
  logic [PC_W-1:0] target;
  logic            redirect;
`ifdef PC_MISALIGN_TRAP_EN
  logic            trap_q, trap_d;
`endif

  pc_target_gen u_target_gen (
    .jal_i    (bus.jal),
    .jalr_i   (bus.jalr),
    .pc_d_i   (dec_pc_q),
    .branoff_i(bus.branoff),
    .target_o (target)
  );

  assign redirect = (state_q == StRun) && dec_vld_q && !bus.stall &&
                    (bus.jal || bus.jalr || (bus.branch && bus.br_taken));

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    dec_pc_d  = dec_pc_q;
    dec_vld_d = dec_vld_q;
    flush_d   = 1'b0;
`ifdef PC_MISALIGN_TRAP_EN
    trap_d    = trap_q;
`endif
    unique case (state_q)
      StIdle, StFlush: begin
        if (!bus.stall) begin
          pc_d      = pc_q + PC_W'(4);
          dec_pc_d  = pc_q;
          dec_vld_d = 1'b1;
          state_d   = StRun;
        end
      end
      StRun: begin
        if (redirect) begin
          pc_d      = target;
          dec_vld_d = 1'b0;
          flush_d   = 1'b1;
          state_d   = StFlush;
`ifdef PC_MISALIGN_TRAP_EN
          if (target[1]) begin
            pc_d    = pc_q;
            trap_d  = 1'b1;
            state_d = StTrap;
          end
`endif
        end else if (!bus.stall) begin
          pc_d      = pc_q + PC_W'(4);
          dec_pc_d  = pc_q;
          dec_vld_d = 1'b1;
        end
      end
`ifdef PC_MISALIGN_TRAP_EN
      StTrap: begin
        if (bus.trap_ack) begin
          pc_d    = RESET_PC;
          trap_d  = 1'b0;
          state_d = StIdle;
        end
      end
`endif
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      pc_q      <= RESET_PC;
      dec_pc_q  <= RESET_PC;
      dec_vld_q <= 1'b0;
      flush_q   <= 1'b0;
`ifdef PC_MISALIGN_TRAP_EN
      trap_q    <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      dec_pc_q  <= dec_pc_d;
      dec_vld_q <= dec_vld_d;
      flush_q   <= flush_d;
`ifdef PC_MISALIGN_TRAP_EN
      trap_q    <= trap_d;
`endif
    end
  end

  assign bus.pc      = pc_q;
  assign bus.pc_d    = dec_pc_q;
  assign bus.valid_d = dec_vld_q;
  assign bus.flush   = flush_q;
`ifdef PC_MISALIGN_TRAP_EN
  assign bus.trap    = trap_q;
`endif

endmodule
